// File: rtl/board_display.sv
// rtl/board_display.sv - scans the board BRAM in step with the XVGA counters and renders cells, border and cursor.
module board_display #(
  parameter int BOARD_SIZE   = 256,
  parameter int WORD_SIZE    = 16,
  parameter int LOG_MAX_ADDR = 12,
  parameter int CELL_SHIFT   = 1,
  parameter int X0           = 256,
  parameter int Y0           = 128,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic                          hsync_in,
  input  logic                          vsync_in,
  input  logic                          blank_in,
  input  logic [WORD_SIZE-1:0]          data_r_in,
  input  logic [$clog2(BOARD_SIZE)-1:0] cursor_x_in,
  input  logic [$clog2(BOARD_SIZE)-1:0] cursor_y_in,
  output logic [LOG_MAX_ADDR-1:0]       addr_r_out,
  output logic [11:0]                   pixel_out,
  output logic                          hsync_out,
  output logic                          vsync_out,
  output logic                          blank_out,
  output logic                          frame_done_out
);
  localparam int CELL_W = $clog2(BOARD_SIZE);
  localparam int IDX_W  = $clog2(WORD_SIZE);
  localparam logic [10:0] SPAN   = 11'(BOARD_SIZE << CELL_SHIFT);
  localparam logic [9:0]  DONE_V = 10'(Y0 + (BOARD_SIZE << CELL_SHIFT));

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             in_board;
    logic             cursor_hit;
    logic             hsync;
    logic             vsync;
    logic             blank;
  } side_t;

  localparam side_t SIDE_RESET = '{idx: '0, in_board: 1'b0, cursor_hit: 1'b0,
                                   hsync: 1'b0, vsync: 1'b0, blank: 1'b1};

  logic [10:0]       px, py;
  logic              in_board;
  logic [CELL_W-1:0] cell_x, cell_y;
  side_t             stage_a;
  side_t             side [READ_LATENCY+1];
  logic              alive;
  logic              armed, done_hit, done_q;

  // Coordinates left of / above the board wrap to large values and fail the range test.
  assign px       = hcount_in - 11'(X0);
  assign py       = {1'b0, vcount_in} - 11'(Y0);
  assign in_board = (px < SPAN) && (py < SPAN);
  assign cell_x   = px[CELL_SHIFT +: CELL_W];
  assign cell_y   = py[CELL_SHIFT +: CELL_W];

  always_comb begin
    stage_a            = SIDE_RESET;
    stage_a.idx        = cell_x[IDX_W-1:0];
    stage_a.in_board   = in_board;
    stage_a.cursor_hit = in_board && (cell_x == cursor_x_in) && (cell_y == cursor_y_in);
    stage_a.hsync      = hsync_in;
    stage_a.vsync      = vsync_in;
    stage_a.blank      = blank_in;
  end

  // MSB of the word is the leftmost cell, so bit WORD_SIZE-1-idx is simply ~idx.
  assign alive    = data_r_in[~side[READ_LATENCY].idx];
  assign done_hit = armed && (hcount_in == 11'd0) && (vcount_in == DONE_V);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_r_out     <= '0;
      pixel_out      <= 12'h000;
      hsync_out      <= 1'b0;
      vsync_out      <= 1'b0;
      blank_out      <= 1'b1;
      frame_done_out <= 1'b0;
      done_q         <= 1'b0;
      armed          <= 1'b1;
      for (int i = 0; i <= READ_LATENCY; i++) side[i] <= SIDE_RESET;
    end else begin
      if (in_board)
        addr_r_out <= LOG_MAX_ADDR'({cell_y, cell_x[CELL_W-1:IDX_W]});
      side[0] <= stage_a;
      for (int i = 1; i <= READ_LATENCY; i++) side[i] <= side[i-1];

      hsync_out <= side[READ_LATENCY].hsync;
      vsync_out <= side[READ_LATENCY].vsync;
      blank_out <= side[READ_LATENCY].blank;
      if (side[READ_LATENCY].blank)
        pixel_out <= 12'h000;
      else if (!side[READ_LATENCY].in_board)
        pixel_out <= 12'h333;
      else if (side[READ_LATENCY].cursor_hit && alive)
        pixel_out <= 12'hF80;
      else if (side[READ_LATENCY].cursor_hit)
        pixel_out <= 12'hF00;
      else if (alive)
        pixel_out <= 12'hFFF;
      else
        pixel_out <= 12'h000;

      // One pulse per frame: disarm on the pulse, re-arm when the next frame starts at line 0.
      done_q         <= done_hit;
      frame_done_out <= done_q;
      if (done_hit)
        armed <= 1'b0;
      else if (vcount_in == 10'd0)
        armed <= 1'b1;
    end
  end
endmodule

// File: tb/tb_board_display.sv
// tb/tb_board_display.sv - randomized and directed checks of board_display against a behavioural model.
module tb_board_display;
  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        hsync, vsync, blank;
  logic [15:0] data_r;
  logic [7:0]  cursor_x, cursor_y;
  logic [11:0] addr_r;
  logic [11:0] pixel;
  logic        hsync_o, vsync_o, blank_o, frame_done;

  board_display dut (
    .clk_in(clk), .rst_in(rst), .hcount_in(hcount), .vcount_in(vcount),
    .hsync_in(hsync), .vsync_in(vsync), .blank_in(blank), .data_r_in(data_r),
    .cursor_x_in(cursor_x), .cursor_y_in(cursor_y), .addr_r_out(addr_r),
    .pixel_out(pixel), .hsync_out(hsync_o), .vsync_out(vsync_o), .blank_out(blank_o),
    .frame_done_out(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [4096];
  logic [11:0] a0 = '0, a1 = '0, a2 = '0;
  logic [14:0] exp_q [$];
  logic [14:0] exp_now;
  logic [11:0] exp_addr;
  bit          exp_fd, fd_next, armed;
  int          fd_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
  endtask

  // Expected {pixel, hsync, vsync, blank} for one sample, straight from the rendering rules.
  function automatic logic [14:0] model_out(int h, int v, bit hs, bit vs, bit bl, int cx, int cy);
    int px, py, x, y;
    bit inb, alive, hit;
    logic [11:0] p;
    px = (h - 256) & 2047;
    py = (v - 128) & 2047;
    inb = (px < 512) && (py < 512);
    x = px / 2;
    y = py / 2;
    alive = inb ? mem[y*16 + x/16][15 - x%16] : 1'b0;
    hit = inb && (x == cx) && (y == cy);
    if (bl) p = 12'h000;
    else if (!inb) p = 12'h333;
    else if (hit && alive) p = 12'hF80;
    else if (hit) p = 12'hF00;
    else if (alive) p = 12'hFFF;
    else p = 12'h000;
    return {p, hs, vs, bl};
  endfunction

  task automatic model_edge();
    int px, py;
    if (rst) begin
      exp_q.delete();
      repeat (4) exp_q.push_back({12'h000, 1'b0, 1'b0, 1'b1});
      exp_addr = '0;
      exp_fd = 1'b0;
      fd_next = 1'b0;
      armed = 1'b1;
    end else begin
      exp_q.push_back(model_out(hcount, vcount, hsync, vsync, blank, cursor_x, cursor_y));
      px = (int'(hcount) - 256) & 2047;
      py = (int'(vcount) - 128) & 2047;
      if (px < 512 && py < 512) exp_addr = 12'((py / 2) * 16 + (px / 2) / 16);
      exp_fd = fd_next;
      fd_next = armed && (hcount == 0) && (vcount == 640);
      if (fd_next) armed = 1'b0;
      else if (vcount == 0) armed = 1'b1;
    end
    exp_now = exp_q.pop_front();
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("pixel", pixel, exp_now[14:3]);
    check("hsync", hsync_o, exp_now[2]);
    check("vsync", vsync_o, exp_now[1]);
    check("blank", blank_o, exp_now[0]);
    check("addr", addr_r, exp_addr);
    check("frame_done", frame_done, exp_fd);
    if (frame_done === 1'b1) fd_seen++;
    // Two-edge BRAM: data for the address visible after edge j-2 is presented after edge j.
    a2 = a1; a1 = a0; a0 = addr_r;
    data_r = mem[a2];
  endtask

  task automatic drive(input int h, input int v, input bit hs, input bit vs, input bit bl);
    hcount = 11'(h); vcount = 10'(v); hsync = hs; vsync = vs; blank = bl;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    mem[0]  = 16'h8000;
    mem[80] = 16'h1800;
    rst = 1'b1; cursor_x = 8'd3; cursor_y = 8'd5; data_r = '0;
    drive(0, 0, 0, 0, 1);
    step(); step();
    rst = 1'b0;

    drive(256, 128, 0, 0, 0); step(); check("addr_first", addr_r, 12'd0);
    drive(258, 128, 0, 0, 0); step();
    drive(286, 128, 0, 0, 0); step(); check("addr_cell15", addr_r, 12'd0);
    drive(288, 128, 0, 0, 0); step(); check("addr_cell16", addr_r, 12'd1);
    drive(256, 130, 0, 0, 0); step(); check("addr_row1", addr_r, 12'd16);
    drive(767, 639, 0, 0, 0); step(); check("addr_last", addr_r, 12'd4095);
    drive(255, 130, 0, 0, 0); step(); check("addr_hold", addr_r, 12'd4095);
    drive(300, 200, 0, 0, 1); step();
    drive(300, 200, 1, 0, 0); step();
    drive(302, 200, 0, 1, 0); step();
    drive(262, 138, 0, 0, 0); step();
    drive(264, 138, 0, 0, 0); step();
    cursor_x = 8'd2;
    drive(260, 138, 0, 0, 0); step();
    drive(0, 0, 0, 0, 1); repeat (4) step();

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) begin
        cursor_x = 8'($urandom); cursor_y = 8'($urandom);
      end
      if ($urandom_range(0, 7) == 0)
        drive(256 + 2*cursor_x + int'($urandom_range(0, 1)), 128 + 2*cursor_y + int'($urandom_range(0, 1)),
              1'($urandom), 1'($urandom), 1'b0);
      else
        drive($urandom_range(200, 820), $urandom_range(100, 680), 1'($urandom), 1'($urandom),
              $urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 499) == 0);
      step();
    end
    rst = 1'b0;

    fd_seen = 0;
    drive(0, 0, 0, 0, 1); step();
    for (int v = 630; v <= 650; v++)
      for (int h = 0; h < 4; h++) begin
        drive(h, v, 0, 0, 1); step();
      end
    drive(0, 640, 0, 0, 1); step(); step();
    check("frame_done_count", fd_seen, 1);
    drive(0, 0, 0, 0, 1); step();
    drive(0, 640, 0, 0, 1); step();
    drive(1, 640, 0, 0, 1); step(); step();
    check("frame_done_rearm", fd_seen, 2);

    drive(400, 300, 1, 1, 0); repeat (4) step();
    rst = 1'b1; step();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      drive(402 + 2*n, 300, 1, 1, 0); step();
      check("post_reset_blank", blank_o, 1'b1);
    end
    repeat (4) step();
    check("resume_blank", blank_o, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
